// File: rtl/spec_fifo_pkg.sv
// Shared types and helpers for the speculative-write FIFO.
// The gray/bin helpers are kept for a future dual-clock variant.
package spec_fifo_pkg;

    typedef enum logic [1:0] {
        OP_IDLE     = 2'd0,
        OP_COMMIT   = 2'd1,
        OP_ROLLBACK = 2'd2,
        OP_DROP     = 2'd3
    } wr_op_e;

    function automatic int ptr_width(input int depth_log2);
        return depth_log2 + 1;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        for (int i = 1; i < 32; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

    // Distance between two lap-bit pointers, modulo 2**pw.
    function automatic logic [31:0] ptr_diff(input logic [31:0] a, input logic [31:0] b,
                                             input int pw);
        logic [31:0] mask;
        mask = (32'd1 << pw) - 32'd1;
        return (a - b) & mask;
    endfunction

endpackage

// File: rtl/spec_fifo_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
module spec_fifo_ram #(
    parameter int WIDTH = 9,
    parameter int AW    = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    (* ram_style = "block" *) logic [WIDTH-1:0] r_mem [0:(1<<AW)-1];
    logic [WIDTH-1:0] r_rdata;

    // Write port.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read; cleared by reset so the head word reads 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata <= {WIDTH{1'b0}};
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/spec_fifo_sync.sv
// FWFT FIFO with speculative write, commit and rollback.
// Define SPEC_FIFO_OVF_DROP_EN to discard packets that suffered an overflow.
module spec_fifo_sync
    import spec_fifo_pkg::*;
#(
    parameter int WIDTH      = 9,
    parameter int DEPTH_LOG2 = 12,
    parameter int AF_MARGIN  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      dataIn,
    input  logic                  writeEn,
    input  logic                  commitWrite,
    input  logic                  rollbackWrite,
    output logic                  full,
    output logic                  almostFull,
    output logic                  overflow,
    output logic                  dropPkt,
    input  logic                  readEn,
    output logic [WIDTH-1:0]      dataOut,
    output logic                  empty,
    output logic                  notEmpty,
    output logic [DEPTH_LOG2:0]   level,
    output logic [DEPTH_LOG2:0]   specLevel
);

    localparam int PW = ptr_width(DEPTH_LOG2);
    localparam logic [PW-1:0] DEPTH_P = PW'(1 << DEPTH_LOG2);
    localparam logic [PW-1:0] AF_P    = PW'(AF_MARGIN);
    localparam logic [PW-1:0] ONE_P   = {{(PW-1){1'b0}}, 1'b1};

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_com_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic          r_empty;
    logic          r_overflow;

    logic [PW-1:0] w_used;
    logic [PW-1:0] w_free;
    logic          w_full;
    logic          w_rb_req;
    logic          w_ovf;
    logic          w_wr_acc;
    logic          w_pop;
    logic          w_poisoned;
    logic [PW-1:0] w_wr_inc;
    logic [PW-1:0] w_wr_next;
    logic [PW-1:0] w_com_next;
    logic [PW-1:0] w_rd_next;
    wr_op_e        w_op;

    assign w_used = PW'(ptr_diff(32'(r_wr_ptr), 32'(r_rd_ptr), PW));
    assign w_free = DEPTH_P - w_used;
    assign w_full = (w_used == DEPTH_P);

    // A same-cycle commit overrides rollback.
    assign w_rb_req = rollbackWrite & ~commitWrite;
    assign w_ovf    = writeEn & w_full & ~w_rb_req;
    assign w_wr_acc = writeEn & ~w_full & ~w_rb_req;
    assign w_wr_inc = w_wr_acc ? (r_wr_ptr + ONE_P) : r_wr_ptr;

    assign w_pop     = readEn & ~r_empty;
    assign w_rd_next = r_rd_ptr + {{(PW-1){1'b0}}, w_pop};

`ifdef SPEC_FIFO_OVF_DROP_EN
    logic r_poison;
    logic r_drop;

    assign w_poisoned = r_poison | w_ovf;

    // Poison tracks an open packet that lost a word; drop pulses when it is discarded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_poison <= 1'b0;
            r_drop   <= 1'b0;
        end else begin
            r_drop <= (w_op == OP_DROP);
            case (w_op)
                OP_DROP:     r_poison <= 1'b0;
                OP_ROLLBACK: r_poison <= 1'b0;
                default:     r_poison <= w_poisoned;
            endcase
        end
    end

    assign dropPkt = r_drop;
`else
    assign w_poisoned = 1'b0;
    assign dropPkt    = 1'b0;
`endif

    // Decode the packet operation and the resulting write/commit pointers.
    always_comb begin
        w_op       = OP_IDLE;
        w_wr_next  = w_wr_inc;
        w_com_next = r_com_ptr;
        if (commitWrite & w_poisoned) begin
            w_op = OP_DROP;
        end else if (commitWrite) begin
            w_op = OP_COMMIT;
        end else if (rollbackWrite) begin
            w_op = OP_ROLLBACK;
        end else begin
            w_op = OP_IDLE;
        end
        case (w_op)
            OP_COMMIT: begin
                w_wr_next  = w_wr_inc;
                w_com_next = w_wr_inc;
            end
            OP_ROLLBACK, OP_DROP: begin
                w_wr_next  = r_com_ptr;
                w_com_next = r_com_ptr;
            end
            default: begin
                w_wr_next  = w_wr_inc;
                w_com_next = r_com_ptr;
            end
        endcase
    end

    // Pointer registers, empty flag and overflow pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= {PW{1'b0}};
            r_com_ptr  <= {PW{1'b0}};
            r_rd_ptr   <= {PW{1'b0}};
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            r_wr_ptr   <= w_wr_next;
            r_com_ptr  <= w_com_next;
            r_rd_ptr   <= w_rd_next;
            // The RAM is reading w_rd_next now; it is valid only if already committed.
            r_empty    <= (r_com_ptr == w_rd_next);
            r_overflow <= w_ovf;
        end
    end

    spec_fifo_ram #(
        .WIDTH (WIDTH),
        .AW    (DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr[DEPTH_LOG2-1:0]),
        .i_wdata (dataIn),
        .i_raddr (w_rd_next[DEPTH_LOG2-1:0]),
        .o_rdata (dataOut)
    );

    assign full       = w_full;
    assign almostFull = (w_free <= AF_P);
    assign overflow   = r_overflow;
    assign empty      = r_empty;
    assign notEmpty   = ~r_empty;
    assign level      = PW'(ptr_diff(32'(r_com_ptr), 32'(r_rd_ptr), PW));
    assign specLevel  = PW'(ptr_diff(32'(r_wr_ptr), 32'(r_com_ptr), PW));

endmodule
